led_arbiter: RTL and testbench



---
 rtl/led_arbiter_pkg.sv | 15 +
 rtl/led_arbiter_if.sv | 23 ++
 rtl/led_arbiter_gpio_debounce.sv | 57 +++++
 rtl/led_arbiter.sv | 122 ++++++++++++
 tb/tb_led_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_arbiter_pkg.sv
// Shared owner/state encoding and counter-width helper for the LED arbiter.
// No logic, so there is no latency and no backpressure.
package led_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_HB    = 2'd0,
        OWN_PI    = 2'd1,
        OWN_PULSE = 2'd2
    } owner_e;

    function automatic int cnt_w(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// Pin-side bundle of the LED arbiter: Pi/pulse requests in, LED and status out.
// Plain wires with no latency; there is no backpressure on any signal.
interface led_arbiter_if;
    import led_arbiter_pkg::*;

    logic   gpio_in;
    logic   pulse_req;
    logic   user_led;
    logic   gpio_level;
    logic   gpio_rise;
    owner_e owner;

    modport master (
        output gpio_in, pulse_req,
        input  user_led, gpio_level, gpio_rise, owner
    );

    modport slave (
        input  gpio_in, pulse_req,
        output user_led, gpio_level, gpio_rise, owner
    );

endinterface

// File: rtl/led_arbiter_gpio_debounce.sv
// Synchronise and debounce the raw Pi GPIO and emit rise/change strobes.
// 2 sync cycles plus DEBOUNCE_CYCLES stable cycles; no backpressure.
module gpio_debounce
    import led_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk12,
    input  logic sys_rst_n,
    input  logic gpio_i,
    output logic level_o,
    output logic rise_o,
    output logic chg_o
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic          chg_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk12 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            chg_q   <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                // Strobes are registered alongside level so they line up with it.
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                chg_q   <= 1'b1;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + DW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign chg_o   = chg_q;

endmodule

// File: rtl/led_arbiter.sv
// Fixed-priority owner of the user LED: pulse > Pi GPIO > heartbeat.
// Owner/LED register one cycle after the triggering event; no backpressure.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HEARTBEAT_DIV   = 6000000,
    parameter int PULSE_CYCLES    = 1200000,
    parameter int IDLE_CYCLES     = 36000000
) (
    input  logic          clk12,
    input  logic          sys_rst_n,
    led_arbiter_if.slave  bus
);

    localparam int HW = cnt_w(HEARTBEAT_DIV);
    localparam int PW = cnt_w(PULSE_CYCLES);
    localparam int IW = cnt_w(IDLE_CYCLES);
    localparam logic [HW-1:0] HB_LAST    = HW'(HEARTBEAT_DIV - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);

    logic gpio_level;
    logic gpio_rise;
    logic gpio_chg;

    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk12     (clk12),
        .sys_rst_n (sys_rst_n),
        .gpio_i    (bus.gpio_in),
        .level_o   (gpio_level),
        .rise_o    (gpio_rise),
        .chg_o     (gpio_chg)
    );

    owner_e        state_q, state_d;
    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic          hb_q, hb_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          led_q, led_d;
    logic          idle_exp;
    logic [IW-1:0] idle_inc;

    always_comb begin
        hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HW'(1);
        hb_d     = hb_q ^ (hb_cnt_q == HB_LAST);
        idle_exp = (idle_q == IDLE_LAST);
        idle_inc = idle_exp ? idle_q : idle_q + IW'(1);
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        idle_d   = idle_q;
        case (state_q)
            OWN_HB: begin
                // Parked at expiry so a pulse taken from HB falls back to HB.
                idle_d = gpio_chg ? '0 : IDLE_LAST;
                if (bus.pulse_req) begin
                    state_d = OWN_PULSE;
                    pcnt_d  = '0;
                end else if (gpio_rise) begin
                    state_d = OWN_PI;
                    idle_d  = '0;
                end
            end
            OWN_PI: begin
                idle_d = gpio_chg ? '0 : idle_inc;
                if (bus.pulse_req) begin
                    state_d = OWN_PULSE;
                    pcnt_d  = '0;
                end else if (!gpio_chg && idle_exp) begin
                    state_d = OWN_HB;
                end
            end
            OWN_PULSE: begin
                idle_d = gpio_chg ? '0 : idle_inc;
                if (bus.pulse_req) begin
                    pcnt_d = '0;
                end else if (pcnt_q == PULSE_LAST) begin
                    if (gpio_chg || !idle_exp) begin
                        state_d = OWN_PI;
                        idle_d  = '0;
                    end else begin
                        state_d = OWN_HB;
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: state_d = OWN_HB;
        endcase
        case (state_d)
            OWN_HB:    led_d = hb_d;
            OWN_PI:    led_d = gpio_level;
            OWN_PULSE: led_d = 1'b1;
            default:   led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk12 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= OWN_HB;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
            pcnt_q   <= '0;
            idle_q   <= '0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
            pcnt_q   <= pcnt_d;
            idle_q   <= idle_d;
            led_q    <= led_d;
        end
    end

    assign bus.user_led   = led_q;
    assign bus.owner      = state_q;
    assign bus.gpio_level = gpio_level;
    assign bus.gpio_rise  = gpio_rise;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with a cycle-stamped expectation queue.
module tb_led_arbiter;

    localparam int SIG_OWN  = 0;
    localparam int SIG_LED  = 1;
    localparam int SIG_LVL  = 2;
    localparam int SIG_RISE = 3;

    typedef struct {
        int         at;
        int         sig;
        logic [1:0] val;
    } exp_t;

    logic clk12 = 1'b0;
    logic sys_rst_n;
    led_arbiter_if bus();

    led_arbiter #(
        .DEBOUNCE_CYCLES (4),
        .HEARTBEAT_DIV   (8),
        .PULSE_CYCLES    (5),
        .IDLE_CYCLES     (20)
    ) dut (
        .clk12     (clk12),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 clk12 = ~clk12;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   rel    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic string sig_name(input int s);
        case (s)
            SIG_OWN: return "owner";
            SIG_LED: return "user_led";
            SIG_LVL: return "gpio_level";
            default: return "gpio_rise";
        endcase
    endfunction

    // Heartbeat phase n cycles after the latest reset release: toggles every 8.
    function automatic logic [1:0] hb_at(input int c);
        return 2'(((c - rel) / 8) % 2);
    endfunction

    task automatic push(input int sig, input int at, input logic [1:0] val);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int i = 0;
        logic [1:0] obs;
        while (i < exp_q.size()) begin
            if (exp_q[i].at <= cyc) begin
                case (exp_q[i].sig)
                    SIG_OWN: obs = bus.owner;
                    SIG_LED: obs = {1'b0, bus.user_led};
                    SIG_LVL: obs = {1'b0, bus.gpio_level};
                    default: obs = {1'b0, bus.gpio_rise};
                endcase
                n_chk++;
                assert (obs === exp_q[i].val) n_pass++;
                else $error("FAIL %s@cyc%0d observed %0d expected %0d",
                            sig_name(exp_q[i].sig), cyc, obs, exp_q[i].val);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk12);
            cyc++;
            drain();
        end
    endtask

    initial begin
        int c0;
        sys_rst_n     = 1'b0;
        bus.gpio_in   = 1'b0;
        bus.pulse_req = 1'b0;
        run(3);

        // Reset values
        push(SIG_OWN, cyc, 2'd0);
        push(SIG_LED, cyc, 2'd0);
        push(SIG_LVL, cyc, 2'd0);
        push(SIG_RISE, cyc, 2'd0);
        drain();

        // Heartbeat ownership after release
        sys_rst_n = 1'b1;
        rel = cyc;
        for (int k = 1; k <= 20; k++) begin
            push(SIG_LED, rel + k, hb_at(rel + k));
            push(SIG_OWN, rel + k, 2'd0);
        end
        run(20);

        // Pi rising edge: debounced level 6 cycles after the edge, grant 1 cycle later
        c0 = cyc;
        bus.gpio_in = 1'b1;
        push(SIG_LVL,  c0 + 5, 2'd0);
        push(SIG_RISE, c0 + 5, 2'd0);
        push(SIG_LVL,  c0 + 6, 2'd1);
        push(SIG_RISE, c0 + 6, 2'd1);
        push(SIG_OWN,  c0 + 6, 2'd0);
        push(SIG_RISE, c0 + 7, 2'd0);
        push(SIG_OWN,  c0 + 7, 2'd1);
        push(SIG_LED,  c0 + 7, 2'd1);
        run(8);

        // 3-cycle glitch low is filtered
        c0 = cyc;
        for (int k = 1; k <= 9; k++) begin
            push(SIG_LVL,  c0 + k, 2'd1);
            push(SIG_RISE, c0 + k, 2'd0);
            push(SIG_OWN,  c0 + k, 2'd1);
        end
        bus.gpio_in = 1'b0;
        run(3);
        bus.gpio_in = 1'b1;
        run(6);

        // Single pulse in PI: 5 cycles of PULSE, then back to PI
        c0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            push(SIG_OWN, c0 + k, 2'd2);
            push(SIG_LED, c0 + k, 2'd1);
        end
        push(SIG_OWN, c0 + 6, 2'd1);
        bus.pulse_req = 1'b1;
        run(1);
        bus.pulse_req = 1'b0;
        run(6);

        // Pi drops: LED follows debounced level one cycle later
        c0 = cyc;
        bus.gpio_in = 1'b0;
        push(SIG_LVL,  c0 + 5, 2'd1);
        push(SIG_LVL,  c0 + 6, 2'd0);
        push(SIG_RISE, c0 + 6, 2'd0);
        push(SIG_LED,  c0 + 6, 2'd1);
        push(SIG_LED,  c0 + 7, 2'd0);
        push(SIG_OWN,  c0 + 7, 2'd1);
        run(8);

        // Retrigger on the third LED-on cycle stretches the pulse to 8 cycles
        c0 = cyc;
        for (int k = 1; k <= 8; k++) begin
            push(SIG_OWN, c0 + k, 2'd2);
            push(SIG_LED, c0 + k, 2'd1);
        end
        push(SIG_OWN, c0 + 9, 2'd1);
        push(SIG_LED, c0 + 9, 2'd0);
        bus.pulse_req = 1'b1;
        run(1);
        bus.pulse_req = 1'b0;
        run(2);
        bus.pulse_req = 1'b1;
        run(1);
        bus.pulse_req = 1'b0;
        run(6);

        // Pi idle timeout back to heartbeat, phase unbroken
        c0 = c0 + 9;
        push(SIG_OWN, c0 + 19, 2'd1);
        push(SIG_OWN, c0 + 20, 2'd0);
        for (int k = 20; k <= 32; k++) push(SIG_LED, c0 + k, hb_at(c0 + k));
        push(SIG_OWN, c0 + 32, 2'd0);
        run(c0 + 32 - cyc);

        // Rise and pulse together in HB: pulse wins; then reset mid-pulse
        c0 = cyc;
        bus.gpio_in = 1'b1;
        push(SIG_RISE, c0 + 6, 2'd1);
        push(SIG_OWN,  c0 + 6, 2'd0);
        push(SIG_OWN,  c0 + 7, 2'd2);
        push(SIG_LED,  c0 + 7, 2'd1);
        push(SIG_OWN,  c0 + 9, 2'd2);
        push(SIG_LVL,  c0 + 9, 2'd1);
        run(6);
        bus.pulse_req = 1'b1;
        run(1);
        bus.pulse_req = 1'b0;
        run(2);
        sys_rst_n = 1'b0;
        #1;
        push(SIG_OWN,  cyc, 2'd0);
        push(SIG_LED,  cyc, 2'd0);
        push(SIG_LVL,  cyc, 2'd0);
        push(SIG_RISE, cyc, 2'd0);
        drain();
        bus.gpio_in = 1'b0;
        run(2);

        // Heartbeat restarts from zero after the second release
        sys_rst_n = 1'b1;
        rel = cyc;
        for (int k = 1; k <= 9; k++) begin
            push(SIG_LED, rel + k, hb_at(rel + k));
            push(SIG_OWN, rel + k, 2'd0);
        end
        run(9);

        n_chk++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL leftover_expectations observed %0d expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
